// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and frame constants for the PS/2 receiver
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // Wide enough to index any bit position within a full frame.
  typedef logic [$clog2(PS2_FRAME_BITS)-1:0] ps2_bit_cnt_t;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser plus FILTER_LEN-sample glitch filter
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      out   <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      // The output flips on the FILTER_LEN-th consecutive differing sample.
      if (sync2 == out) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        out <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver; optional mid-frame timeout via PS2_RX_TIMEOUT_EN
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 6500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err
);

  logic         clk_f;
  logic         data_f;
  logic         clk_q;
  logic         fall;
  logic         clk_edge;
  logic         timeout;
  ps2_state_t   state;
  ps2_bit_cnt_t bit_cnt;
  logic [7:0]   shreg;
  logic         par;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk (clk),
    .rst (rst),
    .in  (ps2_clk),
    .out (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk (clk),
    .rst (rst),
    .in  (ps2_data),
    .out (data_f)
  );

  always_ff @(posedge clk) begin
    if (rst) clk_q <= 1'b1;
    else     clk_q <= clk_f;
  end

  assign fall     = clk_q & ~clk_f;
  assign clk_edge = clk_q ^ clk_f;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Saturates at the limit; the FSM leaves the frame on the same cycle.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || clk_edge) to_cnt <= '0;
    else if (!timeout)                    to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (state != IDLE && timeout && !fall) begin
        frame_err <= 1'b1;
        state     <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_f) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {data_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == ps2_bit_cnt_t'(PS2_DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            par   <= data_f;
            state <= STOP;
          end
          STOP: begin
            if (!data_f) begin
              frame_err <= 1'b1;
            end else if (^{shreg, par}) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - randomized scoreboard bench for ps2_rx
module tb_ps2_rx;

  localparam int FILT    = 8;
  localparam int TO_CYC  = 400;
  localparam int HALF    = 30;
  localparam int GAP     = 80;

  typedef enum int {K_VALID, K_PERR, K_FERR} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;

  int         tests = 0;
  int         failed = 0;
  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;

  ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired: queue=%0d required=0", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk) begin
    if (!rst && (valid || parity_err || frame_err)) begin
      exp_t  e;
      kind_t got;
      tests++;
      if ($countones({valid, parity_err, frame_err}) != 1) begin
        failed++;
        $display("FAIL onehot: got %b required exactly one", {valid, parity_err, frame_err});
      end
      got = valid ? K_VALID : (parity_err ? K_PERR : K_FERR);
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_pulse: got kind %0d required none", got);
      end else begin
        e = exp_q.pop_front();
        if (got != e.kind) begin
          failed++;
          $display("FAIL kind: got %0d required %0d", got, e.kind);
        end
        tests++;
        if (data !== e.data) begin
          failed++;
          $display("FAIL data: got %02h required %02h", data, e.data);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic push(input kind_t k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] d, input bit flip, input bit stop, input int n);
    logic [10:0] f;
    f = {stop, (~^d) ^ flip, d, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // Reference model: a frame's outcome depends only on stop bit and parity.
  task automatic frame(input logic [7:0] d, input bit flip, input bit stop, input int gap);
    if (!stop)     push(K_FERR, last_good);
    else if (flip) push(K_PERR, last_good);
    else begin
      push(K_VALID, d);
      last_good = d;
    end
    send_bits(d, flip, stop, 11);
    wait_cycles(gap);
  endtask

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    tests++;
    if (data !== 8'h00 || valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      failed++;
      $display("FAIL %s: got data=%02h v=%b p=%b f=%b required all 0", name, data, valid,
               parity_err, frame_err);
    end
  endtask

  initial begin
    wait_cycles(4);
    check_idle_outputs("reset_state");
    rst = 1'b0;
    wait_cycles(20);

    frame(8'h1C, 1'b0, 1'b1, GAP);
    frame(8'h1C, 1'b1, 1'b1, GAP);

    // Glitch while data is low: a leaked edge would look like a start bit.
    ps2_data = 1'b0;
    wait_cycles(20);
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(20);
    ps2_data = 1'b1;
    wait_cycles(40);
    frame(8'h5A, 1'b0, 1'b1, GAP);

`ifdef PS2_RX_TIMEOUT_EN
    push(K_FERR, last_good);
    send_bits(8'hA7, 1'b0, 1'b1, 6);
    wait_cycles(TO_CYC + 10);
    frame(8'hF0, 1'b0, 1'b1, GAP);
`endif

    frame(8'hE0, 1'b0, 1'b1, 50);
    frame(8'h75, 1'b0, 1'b1, GAP);
    frame(8'h3C, 1'b0, 1'b0, GAP);

    send_bits(8'h33, 1'b0, 1'b1, 5);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    check_idle_outputs("reset_midframe");
    wait_cycles(GAP);
    frame(8'h29, 1'b0, 1'b1, GAP);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      int         r;
      d = 8'($urandom);
      r = int'($urandom_range(0, 3));
      frame(d, r == 0, r != 1, int'($urandom_range(40, 120)));
    end

    wait_cycles(50);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receive-only PS/2 serial front end that turns the device-driven `ps2_clk`/`ps2_data` lines into validated bytes for the mouse/keyboard decoding inside the VGA project top. It sits directly downstream of the board-level PS/2 pins and upstream of the decoder. It synchronises and deglitches both lines, then deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). It emits one-cycle `valid` pulses together with per-frame error flags.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical synchronised samples required before a filtered line changes level.
- `TIMEOUT_CYCLES`, default 6500: idle `clk` cycles allowed between filtered `ps2_clk` edges mid-frame. The default is 100 µs at 65 MHz.

Ports:
- `clk` in 1: system clock. One clock domain; the block runs from the 65 MHz pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `ps2_clk` in 1: raw PS/2 clock from the pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data from the pin, asynchronous to `clk`.
- `data` out 8: last correctly received byte.
- `valid` out 1: one-cycle pulse; `data` is new this cycle.
- `parity_err` out 1: one-cycle pulse; frame discarded because of bad parity.
- `frame_err` out 1: one-cycle pulse; bad stop bit or timeout.

## Operation
- Each line: 2-FF synchroniser, then glitch filter.
  - Filter output resets to 1.
  - Filter output takes the new level after `FILTER_LEN` consecutive equal samples.
- Bits are sampled on a filtered `ps2_clk` falling edge (filtered level 1→0), using the filtered `ps2_data`.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0, go to DATA and clear the bit counter. On an edge with data=1, stay in IDLE with no flag.
  - DATA: shift into a shift register, LSB first. After the 8th bit go to PARITY.
  - PARITY: store the bit. Parity is OK when the count of ones in the 8 data bits plus the parity bit is odd. Go to STOP.
  - STOP, on an edge, then return to IDLE:
    - stop=1 and parity OK: load `data`, pulse `valid`.
    - stop=1 and parity bad: pulse `parity_err`; `data` unchanged.
    - stop=0: pulse `frame_err` only, regardless of parity.
- At most one of `valid`/`parity_err`/`frame_err` is high in any cycle.
- Reset values: `data`=0, all pulses 0, state IDLE, filtered lines 1, counters 0.
- `rst` has priority over every event. Reset mid-frame drops the partial frame with no flag.
- Back-to-back frames: from STOP the FSM returns to IDLE in the same cycle it decides, so it is ready for the next start bit.

## Timing
- Raw pin change to filtered change: 2 + `FILTER_LEN` cycles.
- Filtered stop-bit falling edge to `valid`/error pulse: 1 cycle, pulses registered.
- `data` holds its value until the next good frame.
- Edge detection uses a registered copy of the filtered clock. The edge pulse lasts exactly one cycle.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined:
  - A counter clears on every filtered `ps2_clk` edge and counts in DATA/PARITY/STOP.
  - When it reaches `TIMEOUT_CYCLES`, pulse `frame_err` for one cycle and return to IDLE.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Not defined: no counter is built. A stalled frame waits indefinitely, and `frame_err` comes only from a bad stop bit.

## Structure
- `ps2_pkg`:
  - state enum `ps2_state_t` (IDLE, DATA, PARITY, STOP);
  - constants `PS2_DATA_BITS`=8 and `PS2_FRAME_BITS`=11.
- Sub-module `ps2_line_filter`:
  - 2-FF sync plus `FILTER_LEN` glitch filter, ports `clk`, `rst`, `in`, `out`;
  - instantiated twice.
- FSM, shift register and timeout live in `ps2_rx`.

## Test plan
Bit period is 40 µs unless stated.
- Good frame:
  - Stimulus: send 0x1C (parity bit 0, stop 1).
  - Required: exactly one `valid` pulse with `data`=0x1C; no error pulses.
- Parity error:
  - Stimulus: send 0x1C with parity bit 1.
  - Required: one `parity_err` pulse; `valid` stays 0; `data` keeps its previous value.
- Glitch rejection:
  - Stimulus: idle lines, then a 3-cycle low pulse on `ps2_clk` with `FILTER_LEN`=8. Follow with frame 0x5A.
  - Required: no bit is captured from the glitch; `data`=0x5A with one `valid`.
- Timeout (with `PS2_RX_TIMEOUT_EN`):
  - Stimulus: stop after start plus 5 data bits, hold lines high for `TIMEOUT_CYCLES`+10 cycles, then send 0xF0.
  - Required: one `frame_err` pulse; then `valid` with `data`=0xF0.
- Back-to-back frames:
  - Stimulus: send 0xE0 then 0x75 with a 50 µs gap.
  - Required: two `valid` pulses in order, with `data` 0xE0 then 0x75.
- Reset mid-frame:
  - Stimulus: assert `rst` for 1 cycle after bit 4 of a frame, then send 0x29.
  - Required: all outputs 0 after reset with no flag pulses; `data`=0x29 with `valid`.
